// File: rtl/tick_stage.sv
// One modulus-MOD counter level: counts on inc, emits a carry on its last count
// and toggles a square-wave register on every carry.
module tick_stage #(
    parameter int unsigned MOD = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     inc,
    output logic [$clog2(MOD)-1:0]   cnt,
    output logic                     carry,
    output logic                     sq
);

    localparam int unsigned W = $clog2(MOD);
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic at_last;

    assign at_last = (cnt == LAST);
    // clear suppresses the carry so no downstream level advances or toggles
    assign carry   = inc & ~clear & at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sq  <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            sq  <= 1'b0;
        end else begin
            if (inc) begin
                cnt <= at_last ? '0 : cnt + W'(1);
            end
            if (carry) begin
                sq <= ~sq;
            end
        end
    end

endmodule

// File: rtl/tick_cascade.sv
// Prescaler plus a cascade of modulus counters producing clock-enable ticks,
// square waves and per-stage counts.
module tick_cascade #(
    parameter int unsigned PRESCALE  = 1_000_000,
    parameter int unsigned STAGES    = 3,
    parameter int unsigned STAGE_MOD = 10,
    parameter int unsigned PW        = $clog2(PRESCALE),
    parameter int unsigned CW        = $clog2(STAGE_MOD)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clear,
    output logic [STAGES:0]        tick,
    output logic [STAGES:0]        sq,
    output logic [STAGES*CW-1:0]   count
);

    logic [PW-1:0] pcnt;
    logic          pre_carry;
    logic          unused_pcnt;

    tick_stage #(
        .MOD(PRESCALE)
    ) u_prescale (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .inc  (en),
        .cnt  (pcnt),
        .carry(pre_carry),
        .sq   (sq[0])
    );

    assign tick[0]     = pre_carry;
    // The prescaler count is kept internal; only its carry leaves the block.
    assign unused_pcnt = ^pcnt;

    // Each level has its own carry net so the chain is a plain AND ripple in one cycle.
    for (genvar g = 0; g < int'(STAGES); g++) begin : g_stage
        logic carry_in;
        logic carry;

        if (g == 0) begin : g_first
            assign carry_in = pre_carry;
        end else begin : g_next
            assign carry_in = g_stage[g-1].carry;
        end

        tick_stage #(
            .MOD(STAGE_MOD)
        ) u_stage (
            .clk  (clk),
            .rst_n(rst_n),
            .clear(clear),
            .inc  (carry_in),
            .cnt  (count[g*CW +: CW]),
            .carry(carry),
            .sq   (sq[g+1])
        );

        assign tick[g+1] = carry;
    end

endmodule

// File: tb/tb_tick_cascade.sv
// Directed bench for tick_cascade: small cascade (4/2x3) plus a default-depth
// instance with a short prescaler for the top-level tick period.
module tb_tick_cascade;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic clear = 1'b0;
    logic en_b = 1'b1;
    logic clear_b = 1'b0;

    logic [2:0]  tick;
    logic [2:0]  sq;
    logic [3:0]  count;
    logic [3:0]  tick_b;
    logic [3:0]  sq_b;
    logic [11:0] count_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    tick_cascade #(
        .PRESCALE (4),
        .STAGES   (2),
        .STAGE_MOD(3)
    ) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .clear(clear),
        .tick (tick),
        .sq   (sq),
        .count(count)
    );

    tick_cascade #(
        .PRESCALE(10)
    ) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en_b),
        .clear(clear_b),
        .tick (tick_b),
        .sq   (sq_b),
        .count(count_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Reset, check the zero state, then release at a falling edge: that is cycle 1.
    task automatic start(input logic en_v);
        rst_n = 1'b0;
        en    = 1'b0;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_sq", 32'(sq), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = en_v;
        cyc   = 1;
        #2;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        logic [2:0] et;
        logic [2:0] es;
        logic [3:0] ec;
        int hi;
        int occ;
        int last;

        // Free run: ticks, square waves and counts follow the cycle number
        start(1'b1);
        hi = 0;
        for (int n = 1; n <= 800; n++) begin
            if (n > 1) begin
                step();
                #2;
            end
            et = {cyc % 36 == 0, cyc % 12 == 0, cyc % 4 == 0};
            es = {1'((cyc - 1) / 36 % 2), 1'((cyc - 1) / 12 % 2), 1'((cyc - 1) / 4 % 2)};
            ec = {2'((cyc - 1) / 12 % 3), 2'((cyc - 1) / 4 % 3)};
            chk("run_tick", 32'(tick), 32'(et));
            chk("run_sq", 32'(sq), 32'(es));
            chk("run_count", 32'(count), 32'(ec));
            if (cyc == 35) chk("pre_wrap_count", 32'(count), 32'hA);
            if (cyc == 36) chk("full_wrap_tick", 32'(tick), 32'h7);
            if (cyc == 37) chk("post_wrap_count", 32'(count), 32'h0);
            if (sq[0]) hi++;
        end
        chk("sq0_duty", 32'(hi), 32'd400);

        // en low for cycles 7..11: frozen state, next tick at cycle 13
        start(1'b1);
        for (int n = 1; n <= 14; n++) begin
            if (n > 1) step();
            en = !(cyc >= 7 && cyc <= 11);
            #2;
            chk("hold_tick", 32'(tick), (cyc == 4 || cyc == 13) ? 32'd1 : 32'd0);
            if (cyc >= 7 && cyc <= 11) chk("hold_count", 32'(count), 32'd1);
            if (cyc == 12) chk("hold_sq", 32'(sq), 32'd1);
            if (cyc == 14) begin
                chk("resume_count", 32'(count), 32'd2);
                chk("resume_sq", 32'(sq), 32'd0);
            end
        end

        // clear in the cycle where tick[0] would fire
        start(1'b1);
        for (int n = 1; n <= 12; n++) begin
            if (n > 1) step();
            clear = (cyc == 8);
            #2;
            chk("clr_tick", 32'(tick), (cyc == 4 || cyc == 12) ? 32'd1 : 32'd0);
            if (cyc == 9) begin
                chk("clr_count", 32'(count), 32'd0);
                chk("clr_sq", 32'(sq), 32'd0);
            end
        end
        clear = 1'b0;

        // asynchronous reset in the middle of a tick cycle
        start(1'b1);
        for (int n = 2; n <= 8; n++) step();
        #2;
        chk("pre_arst_tick", 32'(tick), 32'd1);
        chk("pre_arst_count", 32'(count), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_tick", 32'(tick), 32'd0);
        chk("arst_sq", 32'(sq), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 1;
        #2;
        for (int n = 1; n <= 5; n++) begin
            if (n > 1) begin
                step();
                #2;
            end
            chk("rerun_tick", 32'(tick), (cyc == 4) ? 32'd1 : 32'd0);
        end

        // default-depth instance: tick[3] every 10*10^3 cycles
        start(1'b1);
        occ = 0;
        last = 0;
        for (int n = 1; n <= 40005; n++) begin
            if (n > 1) begin
                step();
                #2;
            end
            if (tick_b[3]) begin
                if (occ == 0) chk("b_first", 32'(cyc), 32'd10000);
                else chk("b_period", 32'(cyc - last), 32'd10000);
                chk("b_all_ticks", 32'(tick_b), 32'hF);
                last = cyc;
                occ++;
            end
        end
        chk("b_occ", 32'(occ), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_cascade.md
# tick_cascade

Parametrised successor to the centisecond clock-modulator chain: a prescaler turns `clk` into a base tick, and a cascade of `STAGES` modulus counters derives slower ticks from it. Each level has a single-cycle enable pulse, a toggling square-wave output and its current count. Downstream timers and displays use the pulses as clock enables instead of clocking logic from divided clocks. The block adds run/hold control, synchronous clear and per-stage counts.

## Interface
Parameters:
- `PRESCALE`, 1_000_000, `clk` cycles per base tick (100 MHz gives a 100 Hz centisecond tick); must be ≥ 2.
- `STAGES`, 3, number of cascaded stages after the prescaler; must be ≥ 1.
- `STAGE_MOD`, 10, modulus of every cascaded stage; must be ≥ 2.
- `PW`, `$clog2(PRESCALE)`, prescaler counter width (derived; do not override).
- `CW`, `$clog2(STAGE_MOD)`, stage counter width (derived; do not override).

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  run enable; when low, all counters hold their value.
- `clear`  in  1  synchronous clear; has priority over `en`.
- `tick`  out  STAGES+1  one-cycle pulses; bit 0 is the base tick and bit k is the output of stage k.
- `sq`  out  STAGES+1  square waves; bit k toggles on each `tick[k]`.
- `count`  out  STAGES*CW  packed stage counts; stage k (1..STAGES) occupies bits `[k*CW-1 : (k-1)*CW]`.

## Operation
- Prescaler `pcnt` (PW bits) counts 0..PRESCALE-1 when `en` is high.
  - It wraps to 0 after PRESCALE-1.
  - `tick[0] = en & ~clear & (pcnt == PRESCALE-1)`, decoded combinationally from registered state.
- Stage k counter `scnt_k` (CW bits) advances only when `tick[k-1]` is high.
  - It counts 0..STAGE_MOD-1 and wraps to 0.
  - `tick[k] = tick[k-1] & (scnt_k == STAGE_MOD-1)`.
  - At a full wrap, all affected ticks are asserted in the same cycle (ripple-free carry chain).
- `sq[k]` is a register that inverts on the edge where `tick[k]` is high. Its period is 2× the tick period of that level and its duty cycle is 50%.
- `en` low: `pcnt`, all `scnt`, and `sq` hold; `tick` is all 0. On the next `en` high, counting resumes from the held value (no restart).
- `clear` high at an edge: `pcnt`, all `scnt` and all `sq` go to 0, and `tick` is all 0 during that cycle. This applies regardless of `en`.
- `rst_n` low: the same zero state as `clear`, applied immediately and asynchronously. Release is synchronous to the next edge. Reset asserted mid-count discards any partial count.
- No out-of-range state is reachable. The comparisons use `==`, so state stays in range regardless.

## Timing
- Reset values: `tick` = 0, `sq` = 0, `count` = 0.
- Latency:
  - With `en` held high after reset release, the first `tick[0]` is high during the PRESCALE-th cycle. Its edge brings `pcnt` back to 0.
  - `tick[k]` has period PRESCALE·STAGE_MOD^k cycles.
  - `sq[k]` changes on the edge that ends the cycle in which `tick[k]` is high.
- `tick` is combinational from registered state and `en`/`clear`. Consumers must sample it synchronously.
- Simultaneous `clear` and a wrap: `clear` wins. No tick is emitted and no `sq` toggle occurs.
- Toggling `en` within a prescale period only stretches that period. The tick count is exact in enabled cycles.

## Structure
- No shared package is needed. Widths are derived locally with `$clog2`, and default moduli are local to the parameter list.
- Sub-module `tick_stage`:
  - Parameter `MOD`.
  - Inputs `clk`, `rst_n`, `clear`, `inc`.
  - Outputs `cnt`, `carry`, `sq`.
  - Instantiated once as the prescaler (MOD = PRESCALE, inc = `en`) and STAGES times in a generate loop (inc = previous carry).

## Test plan
- PRESCALE=4, STAGES=2, STAGE_MOD=3, `en`=1 after reset.
  - `tick[0]` high at cycles 4, 8, 12…
  - `tick[1]` high at cycles 12, 24…
  - `tick[2]` high at cycle 36, coincident with `tick[1]` and `tick[0]`.
  - `count` reads {2,2} just before cycle 36 and {0,0} after it.
- Same configuration, `en` dropped for 5 cycles after cycle 6: no ticks while low, counters frozen, next `tick[0]` at cycle 13.
- `clear` pulsed in the cycle where `tick[0]` would fire: `tick` stays 0, all counts and `sq` become 0, next `tick[0]` 4 enabled cycles later.
- `rst_n` asserted asynchronously mid-period (between edges): outputs go to 0 before the next edge. After release, the cycle-4 first tick repeats.
- `sq[0]`: high from cycle 5 to cycle 8 inclusive and low from cycle 9 to cycle 12 (period 8). Checked for 50% duty over 100 periods.
- Default parameters (PRESCALE=1_000_000, STAGES=3, STAGE_MOD=10), with PRESCALE overridden to 10 for the bench: `tick[3]` period exactly 10_000 cycles over 3 periods.
